// File: rtl/irrigation_scheduler.sv
// Timed valve controller: counts a BCD mm:ss duration down one second per
// TICK_DIV clocks, with pause (hold), abort and invalid-input rejection.
module irrigation_scheduler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       hold,
  input  logic [7:0] dur_min,
  input  logic [7:0] dur_sec,
  output logic       valve,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rem_min,
  output logic [7:0] rem_sec
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [7:0]    rem_min_q, rem_sec_q;
  logic          valve_q, busy_q, done_q, err_q;

  logic          tick, last, dur_ok, dur_zero;
  logic [7:0]    dec_min_d, dec_sec_d;

  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  assign last     = (rem_min_q == 8'h00) && (rem_sec_q == 8'h01);
  assign dur_ok   = (dur_min[7:4] <= 4'd9) && (dur_min[3:0] <= 4'd9) &&
                    (dur_sec[7:4] <= 4'd5) && (dur_sec[3:0] <= 4'd9);
  assign dur_zero = (dur_min == 8'h00) && (dur_sec == 8'h00);

  // One-second BCD decrement with borrow chain; never applied at 00:00.
  always_comb begin
    dec_min_d = rem_min_q;
    dec_sec_d = rem_sec_q;
    if (rem_sec_q[3:0] != 4'd0) begin
      dec_sec_d[3:0] = rem_sec_q[3:0] - 4'd1;
    end else if (rem_sec_q[7:4] != 4'd0) begin
      dec_sec_d = {rem_sec_q[7:4] - 4'd1, 4'd9};
    end else begin
      dec_sec_d = 8'h59;
      if (rem_min_q[3:0] != 4'd0) dec_min_d[3:0] = rem_min_q[3:0] - 4'd1;
      else                        dec_min_d = {rem_min_q[7:4] - 4'd1, 4'd9};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      rem_min_q <= 8'h00;
      rem_sec_q <= 8'h00;
      valve_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (!dur_ok) begin
              err_q <= 1'b1;
            end else if (dur_zero) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= RUN;
              presc_q   <= '0;
              rem_min_q <= dur_min;
              rem_sec_q <= dur_sec;
              valve_q   <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            rem_min_q <= 8'h00;
            rem_sec_q <= 8'h00;
            valve_q   <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick && last) begin
              state_q   <= DONE;
              rem_min_q <= 8'h00;
              rem_sec_q <= 8'h00;
              valve_q   <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              // A non-final tick still lands even if hold pauses us this edge.
              if (tick) begin
                rem_min_q <= dec_min_d;
                rem_sec_q <= dec_sec_d;
              end
              if (hold) begin
                state_q <= HOLD;
                valve_q <= 1'b0;
              end
            end
          end
        end
        HOLD: begin
          if (abort) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            rem_min_q <= 8'h00;
            rem_sec_q <= 8'h00;
            busy_q    <= 1'b0;
          end else if (!hold) begin
            state_q <= RUN;
            valve_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          valve_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign valve   = valve_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rem_min = rem_min_q;
  assign rem_sec = rem_sec_q;

endmodule

// File: doc/irrigation_scheduler.md
IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clk cycles per one-second tick, minimum 2.
REQ-002 Port clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port start  input  1  request to begin an irrigation cycle; sampled only in IDLE.
REQ-005 Port abort  input  1  stop the current cycle immediately, with no done pulse.
REQ-006 Port hold  input  1  level input from the rain/low-tank sensor; pauses watering while high.
REQ-007 Port dur_min  input  8  programmed minutes as two BCD digits [7:4] tens, [3:0] units, range 00-99.
REQ-008 Port dur_sec  input  8  programmed seconds as two BCD digits [7:4] tens 0-5, [3:0] units 0-9.
REQ-009 Port valve  output  1  valve drive, registered; high only in RUN.
REQ-010 Port busy  output  1  high in RUN and in HOLD.
REQ-011 Port done  output  1  single-cycle pulse on normal completion.
REQ-012 Port err  output  1  single-cycle pulse when start is rejected for invalid BCD.
REQ-013 Port rem_min  output  8  remaining minutes in BCD.
REQ-014 Port rem_sec  output  8  remaining seconds in BCD.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, RUN, HOLD and DONE.
REQ-016 In IDLE, start with valid BCD and a nonzero duration SHALL load rem from dur and enter RUN on the next edge.
  - valve=1 on the cycle after start is sampled.
REQ-017 Invalid BCD on start SHALL pulse err for one cycle and leave the FSM in IDLE with rem unchanged.
  - Invalid means any digit >9 or dur_sec tens >5.
REQ-018 A valid start with a 00:00 duration SHALL enter DONE directly; valve is never asserted.
REQ-019 The prescaler SHALL behave as follows.
  - Cleared to 0 on entry to RUN from IDLE.
  - Increments each RUN cycle.
  - Frozen in HOLD.
  - Tick is asserted when prescaler==TICK_DIV-1; the prescaler then wraps to 0.
REQ-020 On each tick, rem SHALL decrement by one second in BCD.
  - sec units 0 borrows from sec tens and becomes 9.
  - sec tens 0 borrows from minutes and becomes 5.
  - min units 0 borrows from min tens and becomes 9.
REQ-021 A tick that makes rem 00:00 SHALL move RUN to DONE on that edge.
  - valve is high for exactly (loaded seconds x TICK_DIV) RUN cycles.
REQ-022 DONE SHALL last one cycle with done=1, valve=0, busy=0, rem=00:00, then return to IDLE.
REQ-023 hold=1 in RUN SHALL enter HOLD on the next edge; hold=0 in HOLD SHALL return to RUN.
  - rem and the prescaler are preserved across HOLD.
REQ-024 Simultaneous events in RUN SHALL resolve in this priority: abort, then final tick (to DONE), then hold.
  - A non-final tick coinciding with hold is applied before entering HOLD.
REQ-025 abort in RUN or HOLD SHALL enter IDLE on the next edge, clear rem to 00:00, and produce no done.
REQ-026 In IDLE, abort and hold SHALL be ignored.
REQ-027 start in RUN, HOLD or DONE SHALL be ignored.
REQ-028 rem SHALL be 00:00 in IDLE except while holding a value loaded by an accepted start.

Reset
REQ-029 reset=0 SHALL asynchronously force the following, independent of clk.
  - FSM to IDLE, prescaler=0, rem=00:00.
  - valve=0, busy=0, done=0, err=0.
REQ-030 After reset deasserts, the first start SHALL be sampled on the first rising clk edge.

Verification (TICK_DIV=4)
REQ-031 dur=00:03, start pulse -> valve high 12 consecutive cycles; rem steps 00:03, 00:02, 00:01, 00:00; then done=1 for 1 cycle; busy low after.
REQ-032 dur=10:00 -> rem=09:59 after the first tick; dur=01:00 -> rem=00:59.
REQ-033 dur=00:02, hold high for 7 cycles starting on RUN cycle 2 -> valve low during HOLD; rem and prescaler frozen; total valve-high cycles still 8; done follows.
REQ-034 dur=00:05, hold asserted, then abort in HOLD -> next cycle IDLE, rem=00:00, busy=0, done never pulses.
REQ-035 dur_sec=8'h60 start -> err=1 for 1 cycle, IDLE retained; dur=00:00 start -> done next cycle, valve never 1.
REQ-036 reset driven low mid-RUN between clk edges -> valve=0, busy=0, rem=00:00 immediately, without waiting for a clock edge.
